mnist_sparse_lut_mlp: RTL and testbench
=======================================

Name: mnist_sparse_lut_mlp

Overview:
Feed-forward binary sparse LUT network for MNIST inference; one fully pipelined image classifier.
- Accepts one 28x28 binarized image (784 bits) per clock with a sideband user tag.
- Produces 70 binary votes: 10 classes x 7 channels.
- A downstream block sums the votes per class and takes the argmax.
- Sits between the image source stream and the vote-accumulation/classification stage.

Parameters:
USER_WIDTH, 1, width of the sideband tag carried alongside each image (e.g. {last, label}).

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
cke  in  1  clock enable; when low the whole pipeline holds state.
in_user  in  USER_WIDTH  sideband tag for the image, passed through unchanged.
in_data  in  784  binarized pixels; bit p = pixel p (row-major, row*28+col).
in_valid  in  1  in_data/in_user qualify this cycle.
out_user  out  USER_WIDTH  tag aligned to out_data.
out_data  out  70  votes; bit j*10+i = channel j vote for class i.
out_valid  out  1  out_data/out_user qualify.

Behaviour:
- One clock; reset is synchronous and active-high. No backpressure and no ready signal. Stalling is done only via cke.
- Three LUT layers, each made of 6-input LUTs with a registered output:
  - L1: 784 -> 1024
  - L2: 1024 -> 480
  - L3: 480 -> 70
- Node n of a layer with input width W drives input k (0..5) from index ((n*6+k)*STRIDE) mod W. STRIDE per layer = 7, 11, 13.
- Node output = INIT[n][addr], where addr = {in5..in0} (in0 = LSB) and INIT is a 64-bit table per node.
- Default INIT for every node = 64'h8000_0000_0000_0000, i.e. a 6-input AND. Trained tables replace these constants without any RTL change.
- Latency = 3 cycles from an accepted input to out_*, at throughput 1 image/clk.
- in_user and in_valid travel through a 3-deep register chain in lockstep with the data stages.
- Data registers update every cke cycle regardless of valid; out_data is only meaningful when out_valid=1.
- cke=0: every register (data, user, valid) holds, including during a stream. Pipeline contents are not lost.
- Reset: out_valid=0, out_user=0, out_data=0, and all intermediate registers = 0. Reset overrides cke.
- Reset mid-stream: images already in flight are discarded and never produce out_valid. The first output after reset is the first input accepted after reset.
- No arithmetic inside the block; vote summation is external.

Optional Feature:
- MNIST_LUT_MLP_INPUT_REG_EN defined: adds a register stage on in_data/in_user/in_valid ahead of L1. Latency becomes 4; reset and cke rules are identical.
- Undefined: inputs feed L1 combinationally; latency is 3.

Decomposition:
- Package mnist_lut_mlp_pkg holds:
  - LUT_K=6
  - IN_W=784, L1_W=1024, L2_W=480, OUT_W=70
  - CLASS_NUM=10, CHANNEL_NUM=7
  - per-layer STRIDE
  - connection-index function
  - per-layer INIT arrays
- One natural sub-module: lut_layer (parameters IN_W, OUT_W, STRIDE, INIT array; ports clk, reset, cke, in, out). It is instantiated 3 times.
- The top level adds the user/valid delay chain.

Test Plan:
- Reset then in_data=all 1s, in_user=5, in_valid=1 for one cycle -> 3 cycles later out_valid=1 for one cycle, out_data=70'h3F_FFFF_FFFF_FFFF_FFFF, out_user=5.
- in_data=all 0s, user=2 -> out_data=0, out_user=2 after 3 cycles.
- Back-to-back 10 images, alternating all-1s/all-0s, user=0..9 -> out_valid high 10 consecutive cycles; user 0..9 in order; data alternating all-1s/0.
- Stream with cke=0 for 4 cycles mid-flight -> outputs frozen during the stall, then resume. Same sequence with no loss or duplication; latency counts only cke=1 cycles.
- Assert reset while 2 images are in flight -> out_valid=0 the cycle after reset and stays 0 until a new input; the discarded images never appear.
- in_valid=0 with garbage data -> out_valid stays 0.

Source files
------------

// File: rtl/mnist_sparse_lut_mlp_pkg.sv
// Package for the sparse binary LUT MNIST classifier.
// Holds network geometry, per-layer wiring strides, the wiring function
// and the per-layer LUT truth tables (INIT). Trained tables replace the
// INIT constants here; no other RTL change is needed.
package mnist_lut_mlp_pkg;

    localparam int LUT_K       = 6;
    localparam int CLASS_NUM   = 10;
    localparam int CHANNEL_NUM = 7;
    localparam int IN_W        = 784;
    localparam int L1_W        = 1024;
    localparam int L2_W        = 480;
    localparam int OUT_W       = CLASS_NUM * CHANNEL_NUM;

    localparam int L1_STRIDE = 7;
    localparam int L2_STRIDE = 11;
    localparam int L3_STRIDE = 13;

    // Only address 6'b111111 returns 1: a 6-input AND.
    localparam logic [63:0] INIT_AND6 = 64'h8000_0000_0000_0000;

    localparam logic [L1_W-1:0][63:0]  L1_INIT = {L1_W{INIT_AND6}};
    localparam logic [L2_W-1:0][63:0]  L2_INIT = {L2_W{INIT_AND6}};
    localparam logic [OUT_W-1:0][63:0] L3_INIT = {OUT_W{INIT_AND6}};

    // Input index feeding LUT input k of node n in a layer of input width w.
    function automatic int conn_idx(input int node, input int k,
                                    input int stride, input int width);
        return ((node * LUT_K + k) * stride) % width;
    endfunction

endpackage

// File: rtl/mnist_sparse_lut_mlp_lut_layer.sv
// lut_layer: one layer of 6-input LUTs with registered outputs.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, clears outputs, overrides cke
//   cke   - clock enable, outputs hold when low
//   in_i  - layer input vector  [IN_W]
//   out_o - registered LUT outputs [OUT_W]
module lut_layer
    import mnist_lut_mlp_pkg::LUT_K;
    import mnist_lut_mlp_pkg::conn_idx;
#(
    parameter int IN_W   = 784,
    parameter int OUT_W  = 1024,
    parameter int STRIDE = 7,
    parameter logic [OUT_W-1:0][63:0] INIT = {OUT_W{64'h8000_0000_0000_0000}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cke,
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);

    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;

    for (genvar n = 0; n < OUT_W; n++) begin : g_node
        logic [LUT_K-1:0] addr;
        for (genvar k = 0; k < LUT_K; k++) begin : g_in
            // Wiring is fixed at elaboration; addr bit k = LUT input k.
            assign addr[k] = in_i[conn_idx(n, k, STRIDE, IN_W)];
        end
        assign out_d[n] = INIT[n][addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else if (cke) begin
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/mnist_sparse_lut_mlp.sv
// mnist_sparse_lut_mlp: fully pipelined binary sparse LUT network.
// One 784-pixel binarized image per clock in, 70 votes out
// (bit j*10+i = channel j vote for class i). Latency 3, or 4 when
// MNIST_LUT_MLP_INPUT_REG_EN is defined (extra input register stage).
// Ports:
//   clk, reset (sync, active-high), cke (global hold)
//   in_user/in_data/in_valid   - image stream in
//   out_user/out_data/out_valid - vote stream out
module mnist_sparse_lut_mlp
    import mnist_lut_mlp_pkg::*;
#(
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    output logic [USER_WIDTH-1:0] out_user,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid
);

    localparam int STAGES = 3;

    logic [IN_W-1:0]       l1_in;
    logic [USER_WIDTH-1:0] user_in;
    logic                  valid_in;

`ifdef MNIST_LUT_MLP_INPUT_REG_EN
    logic [IN_W-1:0]       in_data_q;
    logic [USER_WIDTH-1:0] in_user_q;
    logic                  in_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_data_q  <= '0;
            in_user_q  <= '0;
            in_valid_q <= 1'b0;
        end else if (cke) begin
            in_data_q  <= in_data;
            in_user_q  <= in_user;
            in_valid_q <= in_valid;
        end
    end

    assign l1_in    = in_data_q;
    assign user_in  = in_user_q;
    assign valid_in = in_valid_q;
`else
    assign l1_in    = in_data;
    assign user_in  = in_user;
    assign valid_in = in_valid;
`endif

    logic [L1_W-1:0]  l1_out;
    logic [L2_W-1:0]  l2_out;
    logic [OUT_W-1:0] l3_out;

    lut_layer #(.IN_W(IN_W), .OUT_W(L1_W), .STRIDE(L1_STRIDE), .INIT(L1_INIT)) u_l1 (
        .clk(clk), .reset(reset), .cke(cke), .in_i(l1_in), .out_o(l1_out)
    );

    lut_layer #(.IN_W(L1_W), .OUT_W(L2_W), .STRIDE(L2_STRIDE), .INIT(L2_INIT)) u_l2 (
        .clk(clk), .reset(reset), .cke(cke), .in_i(l1_out), .out_o(l2_out)
    );

    lut_layer #(.IN_W(L2_W), .OUT_W(OUT_W), .STRIDE(L3_STRIDE), .INIT(L3_INIT)) u_l3 (
        .clk(clk), .reset(reset), .cke(cke), .in_i(l2_out), .out_o(l3_out)
    );

    // Sideband chain, one stage per LUT layer so it stays aligned with data.
    logic [STAGES-1:0]                 valid_q;
    logic [STAGES-1:0][USER_WIDTH-1:0] user_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            user_q  <= '0;
        end else if (cke) begin
            valid_q <= {valid_q[STAGES-2:0], valid_in};
            user_q  <= {user_q[STAGES-2:0], user_in};
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_user  = user_q[STAGES-1];
    assign out_data  = l3_out;

endmodule

// File: tb/tb_mnist_sparse_lut_mlp.sv
module tb_mnist_sparse_lut_mlp;

    localparam int UW = 4;
`ifdef MNIST_LUT_MLP_INPUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam logic [69:0] ALL_VOTES = 70'h3F_FFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          cke;
    logic [UW-1:0] in_user;
    logic [783:0]  in_data;
    logic          in_valid;
    logic [UW-1:0] out_user;
    logic [69:0]   out_data;
    logic          out_valid;

    int checks = 0;
    int errors = 0;

    mnist_sparse_lut_mlp #(.USER_WIDTH(UW)) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
        .out_user(out_user), .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [783:0]  data;
        logic [UW-1:0] user;
        logic          valid;
        logic [69:0]   exp;
    } vec_t;

    vec_t vecs[$];

    // Independent reference: three layers of 6-input ANDs on strided taps.
    function automatic logic [69:0] net_model(input logic [783:0] img);
        logic [1023:0] a;
        logic [479:0]  b;
        logic [69:0]   c;
        for (int n = 0; n < 1024; n++) begin
            a[n] = 1'b1;
            for (int k = 0; k < 6; k++) a[n] &= img[((n * 6 + k) * 7) % 784];
        end
        for (int n = 0; n < 480; n++) begin
            b[n] = 1'b1;
            for (int k = 0; k < 6; k++) b[n] &= a[((n * 6 + k) * 11) % 1024];
        end
        for (int n = 0; n < 70; n++) begin
            c[n] = 1'b1;
            for (int k = 0; k < 6; k++) c[n] &= b[((n * 6 + k) * 13) % 480];
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-level pipeline model for the hand-written sequences.
    logic          mv [LAT];
    logic [UW-1:0] mu [LAT];
    logic [69:0]   md [LAT];
    int            n_out;

    task automatic model_clear();
        for (int i = 0; i < LAT; i++) begin
            mv[i] = 1'b0; mu[i] = '0; md[i] = '0;
        end
    endtask

    task automatic cyc(input logic r, input logic ck, input logic v,
                       input logic [UW-1:0] u, input logic [783:0] d, input string tag);
        reset = r; cke = ck; in_valid = v; in_user = u; in_data = d;
        @(posedge clk);
        #1;
        if (r) begin
            model_clear();
        end else if (ck) begin
            for (int i = LAT - 1; i > 0; i--) begin
                mv[i] = mv[i-1]; mu[i] = mu[i-1]; md[i] = md[i-1];
            end
            mv[0] = v; mu[0] = u; md[0] = net_model(d);
        end
        chk({tag, "_valid"}, 70'(out_valid), 70'(mv[LAT-1]));
        chk({tag, "_user"},  70'(out_user),  70'(mu[LAT-1]));
        chk({tag, "_data"},  out_data,       md[LAT-1]);
        if (ck && !r && out_valid) n_out++;
    endtask

    initial begin
        logic [783:0] ones;
        logic [783:0] img;
        logic [783:0] garbage;
        vec_t         v;
        int           nv;
        int           px[3];

        ones = '1;
        garbage = '0;
        for (int i = 0; i < 784; i += 3) garbage[i] = 1'b1;
        px[0] = 0; px[1] = 392; px[2] = 783;

        // Vector table, applied back-to-back one per clock.
        v.data = ones;  v.user = 4'd5; v.valid = 1'b1; v.exp = ALL_VOTES; vecs.push_back(v);
        v.data = '0;    v.user = 4'd2; v.valid = 1'b1; v.exp = '0;        vecs.push_back(v);
        for (int i = 0; i < 10; i++) begin
            v.data = (i % 2 == 0) ? ones : '0;
            v.user = UW'(i);
            v.valid = 1'b1;
            v.exp = (i % 2 == 0) ? ALL_VOTES : '0;
            vecs.push_back(v);
        end
        v.data = garbage; v.user = 4'd15; v.valid = 1'b0; v.exp = '0; vecs.push_back(v);
        for (int i = 0; i < 3; i++) begin
            img = ones;
            img[px[i]] = 1'b0;
            v.data = img; v.user = UW'(8 + i); v.valid = 1'b1; v.exp = net_model(img);
            vecs.push_back(v);
        end
        v.data = garbage; v.user = 4'd14; v.valid = 1'b0; v.exp = '0; vecs.push_back(v);
        nv = vecs.size();

        reset = 1'b1; cke = 1'b1; in_valid = 1'b0; in_user = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 70'(out_valid), 70'd0);
        chk("reset_user",  70'(out_user),  70'd0);
        chk("reset_data",  out_data,       70'd0);
        reset = 1'b0;

        for (int c = 0; c < nv + LAT; c++) begin
            if (c < nv) begin
                in_data = vecs[c].data; in_user = vecs[c].user; in_valid = vecs[c].valid;
            end else begin
                in_data = '0; in_user = '0; in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c < LAT - 1) begin
                chk("fill_valid", 70'(out_valid), 70'd0);
            end else if (c - LAT + 1 < nv) begin
                v = vecs[c - LAT + 1];
                chk($sformatf("vec%0d_valid", c - LAT + 1), 70'(out_valid), 70'(v.valid));
                if (v.valid) begin
                    chk($sformatf("vec%0d_user", c - LAT + 1), 70'(out_user), 70'(v.user));
                    chk($sformatf("vec%0d_data", c - LAT + 1), out_data, v.exp);
                end
            end else begin
                chk("drain_valid", 70'(out_valid), 70'd0);
            end
        end

        // Stall mid-stream: six images, cke low for four cycles with
        // garbage on the inputs, which must not be taken.
        model_clear();
        n_out = 0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, UW'(i + 1), (i % 2 == 0) ? ones : '0, "stall_pre");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 4'd15, garbage, "stall_hold");
        for (int i = 3; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, UW'(i + 1), (i % 2 == 0) ? ones : '0, "stall_post");
        for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0, "stall_drain");
        chk("stall_out_count", 70'(n_out), 70'd6);

        // Reset with two images in flight; cke low shows reset wins.
        n_out = 0;
        cyc(1'b0, 1'b1, 1'b1, 4'd3, ones, "rst_in1");
        cyc(1'b0, 1'b1, 1'b1, 4'd4, ones, "rst_in2");
        cyc(1'b1, 1'b0, 1'b0, '0, '0, "rst_assert");
        for (int i = 0; i < LAT + 2; i++) cyc(1'b0, 1'b1, 1'b0, '0, garbage, "rst_idle");
        chk("rst_discarded", 70'(n_out), 70'd0);
        cyc(1'b0, 1'b1, 1'b1, 4'd7, ones, "rst_new");
        for (int i = 0; i < LAT; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0, "rst_new_drain");
        chk("rst_new_count", 70'(n_out), 70'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
